// File: rtl/ad9914_pkg.sv
// Shared definitions for the AD9914 sweep sequencer: register addresses,
// the sweep-enable mask, FSM state encoding and the segment record.
package ad9914_pkg;

  localparam logic [7:0]  ADDR_SFR1  = 8'h01;
  localparam logic [7:0]  ADDR_LOWER = 8'h04;
  localparam logic [7:0]  ADDR_UPPER = 8'h05;
  localparam logic [7:0]  ADDR_PSTEP = 8'h06;
  localparam logic [7:0]  ADDR_NSTEP = 8'h07;
  localparam logic [7:0]  ADDR_RATE  = 8'h08;

  localparam logic [31:0] SWEEP_EN_MASK = 32'h0008_0000;

  // Index of the final register write of a segment (the SFR1 write).
  localparam logic [2:0]  WORD_LAST = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ACK   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ARM   = 3'd4,
    ST_SWEEP = 3'd5,
    ST_NEXT  = 3'd6
  } state_t;

  typedef struct packed {
    logic [31:0] lower;
    logic [31:0] upper;
    logic [31:0] pstep;
    logic [31:0] nstep;
    logic [31:0] rate;
    logic        dir;
  } seg_t;

  // Register address of the idx-th write of a segment.
  function automatic logic [7:0] word_addr(input logic [2:0] idx);
    logic [7:0] a;
    case (idx)
      3'd0:    a = ADDR_LOWER;
      3'd1:    a = ADDR_UPPER;
      3'd2:    a = ADDR_PSTEP;
      3'd3:    a = ADDR_NSTEP;
      3'd4:    a = ADDR_RATE;
      default: a = ADDR_SFR1;
    endcase
    return a;
  endfunction

  // Data of the idx-th write of a segment; the last write enables the sweep.
  function automatic logic [31:0] word_data(input seg_t seg, input logic [2:0] idx,
                                            input logic [31:0] sfr1_base);
    logic [31:0] d;
    case (idx)
      3'd0:    d = seg.lower;
      3'd1:    d = seg.upper;
      3'd2:    d = seg.pstep;
      3'd3:    d = seg.nstep;
      3'd4:    d = seg.rate;
      default: d = sfr1_base | SWEEP_EN_MASK;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ad9914_seg_table.sv
// Segment table: SEG_NUM-entry register file, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module ad9914_seg_table
  import ad9914_pkg::*;
#(
  parameter int SEG_NUM = 4,
  localparam int IW = $clog2(SEG_NUM)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  seg_t          wdata,
  input  logic [IW-1:0] ridx,
  output seg_t          rdata
);

  seg_t mem [SEG_NUM];

  // Write one entry; indices beyond the table depth are dropped.
  always_ff @(posedge clk) begin
    if (we && (32'(widx) < SEG_NUM)) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ad9914_sweep_seq.sv
// AD9914 sweep sequencer: for each table segment, programs the six sweep
// registers through an external register writer, arms DCTRL and waits for
// DOVER, optionally looping over the table.
// Optional feature: define AD9914_SWEEP_TIMEOUT_EN to add a DOVER watchdog
// that aborts the run after TIMEOUT_CYC cycles in SWEEP.
//
// Writer handshake: a request is offered (wr_load=1, wr_addr/wr_data valid)
// only while wr_finish=1; wr_load and the address/data stay stable until the
// writer raises wr_busy, wr_load drops on the following cycle, and the write
// is complete when wr_finish returns to 1, with wr_res=1 meaning failure.
module ad9914_sweep_seq
  import ad9914_pkg::*;
#(
  parameter int          SEG_NUM     = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000,
  parameter logic [31:0] SFR1_BASE   = 32'h0004_2900,
  localparam int IW = $clog2(SEG_NUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [31:0]   cfg_lower,
  input  logic [31:0]   cfg_upper,
  input  logic [31:0]   cfg_pstep,
  input  logic [31:0]   cfg_nstep,
  input  logic [31:0]   cfg_rate,
  input  logic          cfg_dir,
  input  logic [IW:0]   seg_count,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [IW-1:0] cur_seg,
  input  logic          dover,
  output logic          dctrl,
  output logic          wr_load,
  output logic [7:0]    wr_addr,
  output logic [31:0]   wr_data,
  input  logic          wr_busy,
  input  logic          wr_finish,
  input  logic          wr_res,
  output state_t        fsm_state
);

  state_t        state, state_d;
  logic          busy_d, done_d, err_d, dctrl_d, wr_load_d;
  logic [7:0]    wr_addr_d;
  logic [31:0]   wr_data_d;
  logic [IW-1:0] cur_seg_d, count_m1, count_m1_d;
  logic [2:0]    word_idx, word_idx_d;
  logic [IW:0]   count_clamped;
  logic          stop_pend, stop_now;
  logic          dover_q, dover_rise;
  logic          timeout;
  logic          table_we;
  seg_t          seg_wr, seg_rd;

  assign table_we   = cfg_we && (state == ST_IDLE);
  assign seg_wr     = '{lower: cfg_lower, upper: cfg_upper, pstep: cfg_pstep,
                        nstep: cfg_nstep, rate: cfg_rate, dir: cfg_dir};
  assign stop_now   = stop | stop_pend;
  assign dover_rise = dover & ~dover_q;
  assign fsm_state  = state;

  ad9914_seg_table #(.SEG_NUM(SEG_NUM)) u_table (
    .clk   (clk),
    .we    (table_we),
    .widx  (cfg_idx),
    .wdata (seg_wr),
    .ridx  (cur_seg),
    .rdata (seg_rd)
  );

`ifdef AD9914_SWEEP_TIMEOUT_EN
  logic [23:0] wdog;

  assign timeout = (wdog == TIMEOUT_CYC - 24'd1);

  // Count cycles spent in SWEEP; any other state restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog <= '0;
    end else if (state == ST_SWEEP) begin
      wdog <= wdog + 24'd1;
    end else begin
      wdog <= '0;
    end
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Clamp the requested segment count into 1..SEG_NUM.
  always_comb begin
    count_clamped = seg_count;
    if (seg_count == '0) begin
      count_clamped = (IW+1)'(1);
    end else if (32'(seg_count) > SEG_NUM) begin
      count_clamped = (IW+1)'(SEG_NUM);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (start && !stop) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (stop_now)       state_d = ST_IDLE;
        else if (wr_finish) state_d = ST_ACK;
      end
      ST_ACK:   if (wr_busy) state_d = ST_WAIT;
      ST_WAIT: begin
        if (wr_finish) begin
          if (wr_res)                     state_d = ST_IDLE;
          else if (word_idx == WORD_LAST) state_d = ST_ARM;
          else                            state_d = ST_ISSUE;
        end
      end
      ST_ARM:   state_d = ST_SWEEP;
      ST_SWEEP: begin
        if (stop_now || timeout) state_d = ST_IDLE;
        else if (dover_rise)     state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if ((cur_seg < count_m1) || loop_en) state_d = ST_ISSUE;
        else                                 state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and datapath.
  always_comb begin
    busy_d     = busy;
    done_d     = done;
    err_d      = err;
    dctrl_d    = dctrl;
    wr_load_d  = wr_load;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    cur_seg_d  = cur_seg;
    count_m1_d = count_m1;
    word_idx_d = word_idx;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cur_seg_d  = '0;
          word_idx_d = '0;
          count_m1_d = IW'(count_clamped - 1'b1);
        end
      end
      ST_ISSUE: begin
        if (stop_now) begin
          dctrl_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end else if (wr_finish) begin
          wr_load_d = 1'b1;
          wr_addr_d = word_addr(word_idx);
          wr_data_d = word_data(seg_rd, word_idx, SFR1_BASE);
        end
      end
      ST_ACK: begin
        if (wr_busy) wr_load_d = 1'b0;
      end
      ST_WAIT: begin
        if (wr_finish) begin
          if (wr_res) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dctrl_d = 1'b0;
          end else begin
            word_idx_d = word_idx + 3'd1;
          end
        end
      end
      ST_ARM: begin
        dctrl_d = seg_rd.dir;
      end
      ST_SWEEP: begin
        if (stop_now) begin
          dctrl_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end else if (timeout) begin
          err_d   = 1'b1;
          dctrl_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_NEXT: begin
        dctrl_d    = 1'b0;
        word_idx_d = '0;
        if (cur_seg < count_m1) begin
          cur_seg_d = cur_seg + 1'b1;
        end else if (loop_en) begin
          cur_seg_d = '0;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output/datapath registers, pending-stop flag and DOVER edge history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b1;
      err       <= 1'b0;
      dctrl     <= 1'b0;
      wr_load   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cur_seg   <= '0;
      count_m1  <= '0;
      word_idx  <= '0;
      stop_pend <= 1'b0;
      dover_q   <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      dctrl     <= dctrl_d;
      wr_load   <= wr_load_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      cur_seg   <= cur_seg_d;
      count_m1  <= count_m1_d;
      word_idx  <= word_idx_d;
      // A stop seen mid-write is remembered until the next ISSUE/SWEEP.
      if ((state == ST_IDLE) || (state_d == ST_IDLE)) stop_pend <= 1'b0;
      else                                            stop_pend <= stop_pend | stop;
      dover_q   <= dover;
    end
  end

endmodule

// File: tb/tb_ad9914_sweep_seq.sv
// Testbench for ad9914_sweep_seq: table-driven segment-count runs plus
// hand-written sequences for looping/stop, writer error, busy-time config,
// reset mid-write and the DOVER watchdog (AD9914_SWEEP_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_ad9914_sweep_seq;
  import ad9914_pkg::*;

  typedef struct packed {
    logic [31:0] lower, upper, pstep, nstep, rate;
    logic        dir;
  } tb_seg_t;

  typedef struct {
    logic [2:0] seg_count;
    int         nseg;
    string      tag;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_lower = '0, cfg_upper = '0, cfg_pstep = '0, cfg_nstep = '0, cfg_rate = '0;
  logic        cfg_dir = 1'b0;
  logic [2:0]  seg_count = '0;
  logic        loop_en = 1'b0, start = 1'b0, stop = 1'b0, dover = 1'b0;
  logic        busy, done, err, dctrl, wr_load;
  logic [1:0]  cur_seg;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_busy = 1'b0, wr_finish = 1'b1, wr_res = 1'b0;
  state_t      fsm_state;

  int          n_vec = 0, n_err = 0;
  logic [39:0] exp_q[$];
  logic [39:0] wlog[$];
  tb_seg_t     model_tbl[4];
  logic [7:0]  exp_addr[6] = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h01};
  vec_t        vecs[5];
  logic        fail_en = 1'b0;
  logic [7:0]  fail_addr = 8'h00;
  int          wcnt = 0;

  ad9914_sweep_seq #(.SEG_NUM(4), .TIMEOUT_CYC(24'd100), .SFR1_BASE(32'h0004_2900)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_lower(cfg_lower), .cfg_upper(cfg_upper), .cfg_pstep(cfg_pstep),
    .cfg_nstep(cfg_nstep), .cfg_rate(cfg_rate), .cfg_dir(cfg_dir),
    .seg_count(seg_count), .loop_en(loop_en), .start(start), .stop(stop),
    .busy(busy), .done(done), .err(err), .cur_seg(cur_seg),
    .dover(dover), .dctrl(dctrl), .wr_load(wr_load), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_busy(wr_busy), .wr_finish(wr_finish), .wr_res(wr_res),
    .fsm_state(fsm_state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  // Register-writer model: accepts a load, busy for 3 cycles, then finishes.
  always @(negedge clk) begin
    if (!rst) begin
      wr_busy = 1'b0; wr_finish = 1'b1; wr_res = 1'b0; wcnt = 0;
    end else if (wcnt > 0) begin
      wcnt = wcnt - 1;
      if (wcnt == 0) begin
        wr_busy = 1'b0; wr_finish = 1'b1;
      end
    end else if (wr_load && !wr_busy) begin
      wlog.push_back({wr_addr, wr_data});
      wr_busy = 1'b1; wr_finish = 1'b0;
      wr_res = fail_en && (wr_addr == fail_addr);
      wcnt = 3;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    int n = 0;
    while (fsm_state !== s && n < budget) begin tick(); n++; end
    n_vec++;
    if (fsm_state !== s) begin
      n_err++;
      $display("FAIL %s_wait: state %0d, expected %0d within %0d cycles", name, fsm_state, s, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(); n++; end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle: busy %b, expected 0 within %0d cycles", name, busy, budget);
    end
  endtask

  function automatic logic [31:0] word_of(input tb_seg_t s, input int w);
    case (w)
      0: return s.lower;
      1: return s.upper;
      2: return s.pstep;
      3: return s.nstep;
      4: return s.rate;
      default: return 32'h000C_2900;
    endcase
  endfunction

  task automatic write_seg(input int idx, input tb_seg_t s);
    cfg_idx = 2'(idx); cfg_lower = s.lower; cfg_upper = s.upper; cfg_pstep = s.pstep;
    cfg_nstep = s.nstep; cfg_rate = s.rate; cfg_dir = s.dir; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    model_tbl[idx] = s;
  endtask

  task automatic prep_exp(input int nseg);
    exp_q.delete();
    wlog.delete();
    for (int s = 0; s < nseg; s++)
      for (int w = 0; w < 6; w++)
        exp_q.push_back({exp_addr[w], word_of(model_tbl[s], w)});
  endtask

  task automatic pulse_start(input logic [2:0] cnt);
    seg_count = cnt; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive DOVER per segment and check segment order, DCTRL and write log.
  task automatic finish_run(input int nseg, input string tag);
    for (int s = 0; s < nseg; s++) begin
      wait_state(ST_SWEEP, 200, tag);
      check({tag, "_cur_seg"}, 64'(cur_seg), 64'(s));
      check({tag, "_dctrl"}, 64'(dctrl), 64'(model_tbl[s].dir));
      dover = 1'b1; tick(); dover = 1'b0;
    end
    wait_idle(50, tag);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_dctrl_end"}, 64'(dctrl), 64'd0);
    check({tag, "_nwrites"}, 64'(wlog.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wlog.size() > 0)
      check({tag, "_write"}, 64'(wlog.pop_front()), 64'(exp_q.pop_front()));
  endtask

  task automatic run_one(input logic [2:0] cnt, input int nseg, input string tag);
    prep_exp(nseg);
    pulse_start(cnt);
    finish_run(nseg, tag);
  endtask

  initial begin
    int n;
    int seq_seg[5] = '{0, 1, 2, 0, 1};

    // Reset state
    repeat (3) tick();
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    check("rst_dctrl", 64'(dctrl), 64'd0);
    check("rst_wr_load", 64'(wr_load), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_cur_seg", 64'(cur_seg), 64'd0);
    rst = 1'b1;
    tick();

    // Table contents
    write_seg(0, '{32'd1105322465, 32'd1421128884, 32'd12632, 32'd12632, 32'h0001_0001, 1'b1});
    write_seg(1, '{32'h1000_0000, 32'h2000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0003_0004, 1'b0});
    write_seg(2, '{32'h3000_0000, 32'h3800_0000, 32'h0000_0011, 32'h0000_0022, 32'h0005_0006, 1'b1});
    write_seg(3, '{32'hA000_0000, 32'hB000_0000, 32'h0000_0033, 32'h0000_0044, 32'h0007_0008, 1'b0});

    // Segment-count vectors: {seg_count, segments executed}
    vecs[0] = '{3'd1, 1, "cnt1"};
    vecs[1] = '{3'd0, 1, "cnt0"};
    vecs[2] = '{3'd2, 2, "cnt2"};
    vecs[3] = '{3'd4, 4, "cnt4"};
    vecs[4] = '{3'd7, 4, "cnt7"};
    for (int i = 0; i < 5; i++) begin
      run_one(vecs[i].seg_count, vecs[i].nseg, vecs[i].tag);
      tick();
    end

    // Looping over three segments, then stop during seg1 SWEEP
    loop_en = 1'b1;
    pulse_start(3'd3);
    for (int k = 0; k < 5; k++) begin
      wait_state(ST_SWEEP, 200, "loop");
      check("loop_cur_seg", 64'(cur_seg), 64'(seq_seg[k]));
      check("loop_dctrl", 64'(dctrl), 64'(model_tbl[seq_seg[k]].dir));
      if (k < 4) begin
        dover = 1'b1; tick(); dover = 1'b0;
      end
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_state", 64'(fsm_state), 64'(ST_IDLE));
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_done", 64'(done), 64'd1);
    check("stop_err", 64'(err), 64'd0);
    check("stop_dctrl", 64'(dctrl), 64'd0);
    loop_en = 1'b0;
    tick();

    // Writer failure on the 0x06 write
    wlog.delete();
    fail_en = 1'b1; fail_addr = 8'h06;
    pulse_start(3'd1);
    wait_idle(100, "wrerr");
    check("wrerr_err", 64'(err), 64'd1);
    check("wrerr_busy", 64'(busy), 64'd0);
    check("wrerr_state", 64'(fsm_state), 64'(ST_IDLE));
    check("wrerr_nwrites", 64'(wlog.size()), 64'd3);
    if (wlog.size() > 0) check("wrerr_last_addr", 64'(wlog[wlog.size()-1][39:32]), 64'h06);
    fail_en = 1'b0;
    tick();

    // Table write and start while busy are ignored; second run re-reads seg0
    prep_exp(1);
    pulse_start(3'd1);
    wait_state(ST_ACK, 50, "busy_cfg");
    cfg_idx = 2'd0; cfg_lower = 32'hDEAD_BEEF; cfg_upper = 32'hDEAD_BEEF; cfg_pstep = 32'h1;
    cfg_nstep = 32'h2; cfg_rate = 32'h3; cfg_dir = 1'b0; cfg_we = 1'b1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check("busy_start_cur_seg", 64'(cur_seg), 64'd0);
    check("busy_start_busy", 64'(busy), 64'd1);
    finish_run(1, "busy_cfg");
    tick();
    run_one(3'd1, 1, "reread");
    tick();

    // Reset during ACK of the 0x05 write
    pulse_start(3'd1);
    n = 0;
    while (!(wr_load === 1'b1 && wr_addr === 8'h05) && n < 100) begin tick(); n++; end
    check("rstack_reached", 64'(wr_load && wr_addr == 8'h05), 64'd1);
    rst = 1'b0;
    tick();
    check("rstack_wr_load", 64'(wr_load), 64'd0);
    check("rstack_busy", 64'(busy), 64'd0);
    check("rstack_done", 64'(done), 64'd1);
    check("rstack_state", 64'(fsm_state), 64'(ST_IDLE));
    tick();
    rst = 1'b1;
    tick();
    run_one(3'd1, 1, "post_rst");
    tick();

    // DOVER never toggles
    pulse_start(3'd1);
    wait_state(ST_SWEEP, 200, "dover_stuck");
`ifdef AD9914_SWEEP_TIMEOUT_EN
    n = 0;
    while (busy === 1'b1 && n < 300) begin tick(); n++; end
    check("timeout_cycles", 64'(n), 64'd100);
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_done", 64'(done), 64'd1);
    check("timeout_dctrl", 64'(dctrl), 64'd0);
`else
    repeat (10000) tick();
    check("no_timeout_busy", 64'(busy), 64'd1);
    check("no_timeout_state", 64'(fsm_state), 64'(ST_SWEEP));
    check("no_timeout_err", 64'(err), 64'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("no_timeout_stop_state", 64'(fsm_state), 64'(ST_IDLE));
    check("no_timeout_stop_done", 64'(done), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ad9914_sweep_seq.md
AD9914_SWEEP_SEQ -- requirements
Module: ad9914_sweep_seq

Interface
REQ-001 SHALL have parameter SEG_NUM, default 4: segment table depth, range 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 24'd10_000_000: dover watchdog limit in clk cycles.
REQ-003 SHALL have parameter SFR1_BASE, default 32'h0004_2900: base image of control register 0x01.
REQ-004 clk  in  1  system clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 cfg_we / cfg_idx  in  1 / clog2(SEG_NUM)  write strobe and segment index for the table.
REQ-007 cfg_lower, cfg_upper, cfg_pstep, cfg_nstep, cfg_rate  in  32 each  segment fields; cfg_rate = {neg_rate, pos_rate}.
REQ-008 cfg_dir  in  1  segment sweep direction: 1 = positive, 0 = negative.
REQ-009 seg_count  in  clog2(SEG_NUM)+1  number of active segments.
REQ-010 loop_en / start / stop  in  1 each  repeat the table; start pulse; abort pulse.
REQ-011 busy / done / err  out  1 each  run active; run ended (level); run aborted on a write error or a timeout.
REQ-012 cur_seg  out  clog2(SEG_NUM)  segment currently executing.
REQ-013 dover  in  1  DDS sweep-complete pin.
REQ-014 dctrl  out  1  DDS sweep direction pin.
REQ-015 wr_load, wr_addr[7:0], wr_data[31:0]  out  register-writer request.
REQ-016 wr_busy, wr_finish, wr_res  in  1 each  register-writer status; wr_res = 1 at finish means failure.

Function
REQ-017 FSM states SHALL be: IDLE, ISSUE, ACK, WAIT, ARM, SWEEP, NEXT.
REQ-018 The segment table SHALL accept cfg_we only in IDLE; in every other state cfg_we SHALL be ignored.
REQ-019 When start is asserted in IDLE and stop is not, the block SHALL latch seg_count, clear done/err, set busy=1, set cur_seg=0, and go to ISSUE.
REQ-020 seg_count=0 SHALL be treated as 1; seg_count>SEG_NUM SHALL be clamped to SEG_NUM.
REQ-021 Per segment, ISSUE SHALL write, in order:
  - addr 0x04 lower
  - addr 0x05 upper
  - addr 0x06 pstep
  - addr 0x07 nstep
  - addr 0x08 rate
  - addr 0x01 SFR1_BASE|32'h0008_0000
REQ-022 Write handshake:
  - ISSUE asserts wr_load with wr_addr/wr_data only while wr_finish=1.
  - ACK holds wr_load until wr_busy=1, then deasserts it in the next cycle.
  - WAIT waits for wr_finish=1.
REQ-023 wr_addr and wr_data SHALL stay stable from the wr_load rising edge until wr_busy is seen.
REQ-024 If wr_res=1 when wr_finish arrives in WAIT, the block SHALL set err=1 and go to IDLE.
REQ-025 After the sixth write, ARM SHALL drive dctrl=cfg_dir of the segment for one cycle, then go to SWEEP.
REQ-026 SWEEP SHALL wait for a dover rising edge; dover already high on entry SHALL NOT count as an edge.
REQ-027 NEXT SHALL deassert dctrl, then:
  - if cur_seg < count-1: cur_seg+1, go to ISSUE;
  - else if loop_en=1: cur_seg=0, go to ISSUE;
  - else: go to IDLE with busy=0, done=1.
REQ-028 stop SHALL be sampled in every non-IDLE state and honoured at the next ISSUE or SWEEP (never mid-write).
REQ-029 On stop, the block SHALL set dctrl=0, busy=0, done=1, err=0, and go to IDLE.
REQ-030 start while busy SHALL be ignored; start and stop in the same cycle: stop wins.
REQ-031 Segment index arithmetic SHALL be unsigned and wrap only through the loop_en path.

Reset
REQ-032 While rst=0, the block SHALL force:
  - state IDLE
  - busy=0, done=1, err=0
  - dctrl=0, wr_load=0, wr_addr=0, wr_data=0, cur_seg=0
  - watchdog counter 0
REQ-033 Table contents SHALL be preserved across reset.
REQ-034 A reset during a write SHALL drop wr_load immediately; the writer's own reset governs its recovery.

Configuration
REQ-035 With AD9914_SWEEP_TIMEOUT_EN defined, SWEEP SHALL count cycles; on reaching TIMEOUT_CYC without a dover edge it SHALL set err=1, dctrl=0, busy=0, done=1, and go to IDLE.
REQ-036 Without AD9914_SWEEP_TIMEOUT_EN, SWEEP SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-037 Package ad9914_pkg SHALL hold:
  - register address constants 0x01, 0x04–0x08
  - sweep-enable mask 32'h0008_0000
  - FSM state enum
  - segment struct (lower, upper, pstep, nstep, rate, dir)
REQ-038 The segment table SHALL be sub-module ad9914_seg_table: SEG_NUM-entry register file, one synchronous write port, one combinational read port indexed by cur_seg.

Verification
REQ-039 Single-segment run: write seg0 (lower 1105322465, upper 1421128884, steps 12632, rate 32'h0001_0001, dir 1), seg_count=1, start, writer model ack in 3 cycles.
  - Required: exactly six writes at 0x04, 0x05, 0x06, 0x07, 0x08, 0x01 with matching data.
  - Required: dctrl=1 until a dover pulse; then done=1, busy=0.
REQ-040 Three segments, loop_en=1, dirs 1/0/1: cur_seg sequence 0,1,2,0; dctrl follows the dirs; stop during seg1 SWEEP gives IDLE within 2 cycles, done=1, err=0.
REQ-041 Writer returns wr_res=1 on the 0x06 write: err=1, busy=0, no 0x07 write issued.
REQ-042 AD9914_SWEEP_TIMEOUT_EN with TIMEOUT_CYC=100, dover never toggles: err=1 after 100 SWEEP cycles; the same stimulus without the macro stays busy for 10,000 cycles.
REQ-043 Reset asserted during ACK of the 0x05 write: next cycle wr_load=0, busy=0, done=1; a later start with the table unrewritten writes seg0 original values.
REQ-044 cfg_we while busy: table unchanged (read back by a second run); start while busy: no effect; seg_count=0: runs one segment.
